// File: rtl/aemb_intc.sv
// AEMB Wishbone interrupt controller: synchronised sources, ISR/IER/IVR/MER.
// Define AEMB_INTC_EDGE_EN for rising-edge triggering; level mode otherwise.
module aemb_intc #(
  parameter int NUM_SRC = 8
) (
  input  logic               sys_clk_i,
  input  logic               sys_rst_i,
  input  logic [NUM_SRC-1:0] int_src_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [1:0]         wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               irq_o
);

  logic [NUM_SRC-1:0] s1, s2, set;
  logic [NUM_SRC-1:0] isr, ier, pend, wdat, clr;
  logic               mer;
  logic               acc, wr;
  logic [31:0]        ivr, rdat;
  logic               unused_ok;

`ifdef AEMB_INTC_EDGE_EN
  logic [NUM_SRC-1:0] s3;

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) s3 <= '0;
    else           s3 <= s2;
  end

  assign set = s2 & ~s3;
`else
  assign set = s2;
`endif

  // A transfer starts only while ack is low, forcing a gap cycle.
  assign acc  = wb_stb_i & ~wb_ack_o;
  assign wr   = acc & wb_we_i;
  assign wdat = wb_dat_i[NUM_SRC-1:0];
  assign clr  = (wr && wb_adr_i == 2'd0) ? wdat : '0;
  assign pend = isr & ier;

  assign unused_ok = ^wb_dat_i;

  always_comb begin
    ivr = 32'h0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend[i]) ivr = 32'h8000_0000 | 32'(i);
    end
  end

  always_comb begin
    rdat = 32'h0;
    unique case (wb_adr_i)
      2'd0: rdat = 32'(isr);
      2'd1: rdat = 32'(ier);
      2'd2: rdat = ivr;
      2'd3: rdat = {31'h0, mer};
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      s1       <= '0;
      s2       <= '0;
      isr      <= '0;
      ier      <= '0;
      mer      <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'h0;
      irq_o    <= 1'b0;
    end else begin
      s1       <= int_src_i;
      s2       <= s1;
      isr      <= set | (isr & ~clr);
      if (wr && wb_adr_i == 2'd1) ier <= wdat;
      if (wr && wb_adr_i == 2'd3) mer <= wb_dat_i[0];
      wb_ack_o <= acc;
      wb_dat_o <= acc ? rdat : 32'h0;
      irq_o    <= mer & |pend;
    end
  end

endmodule

// File: doc/aemb_intc.md
AEMB_INTC -- requirements
Module: aemb_intc

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of interrupt sources (legal range 1..32).
REQ-002 SHALL have port sys_clk_i, input, 1, the only clock; all state changes on its rising edge.
REQ-003 SHALL have port sys_rst_i, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port int_src_i, input, NUM_SRC, asynchronous interrupt request lines, active-high.
REQ-005 SHALL have port wb_stb_i, input, 1, slave strobe (cycle and strobe combined).
REQ-006 SHALL have port wb_we_i, input, 1, write enable.
REQ-007 SHALL have port wb_adr_i, input, 2, word address; it is the byte address [3:2].
REQ-008 SHALL have port wb_dat_i, input, 32, write data.
REQ-009 SHALL have port wb_dat_o, output, 32, read data.
REQ-010 SHALL have port wb_ack_o, output, 1, transfer acknowledge.
REQ-011 SHALL have port irq_o, output, 1, registered interrupt request to the core's sys_int_i.

Function
REQ-012 SHALL pass each int_src_i bit through a two-flop synchroniser (s1, s2) before any use.
REQ-013 SHALL hold registers ISR (addr 0, pending, write-1-to-clear), IER (addr 1, enable mask, read/write), IVR (addr 2, read-only) and MER (addr 3, bit0 master enable, read/write).
REQ-014 SHALL read register bits at or above NUM_SRC as 0 and ignore writes to them; MER bits 31:1 read 0.
REQ-015 SHALL set ISR[i] on the edge after the set condition for source i holds (REQ-030/031), independent of IER and MER.
REQ-016 SHALL give set priority over a write-1-to-clear when both hit the same ISR bit in one cycle.
REQ-017 SHALL return in IVR 0x80000000 | i, where i is the lowest index with ISR[i] & IER[i]; it SHALL return 0x00000000 if none.
REQ-018 SHALL register irq_o as MER[0] & |(ISR & IER), so irq_o follows register state with one cycle latency.
REQ-019 SHALL assert wb_ack_o for exactly one cycle, on the edge after wb_stb_i is sampled high with wb_ack_o low.
REQ-020 SHALL therefore deassert wb_ack_o for at least one cycle between back-to-back transfers (two cycles per access).
REQ-021 SHALL perform a register write on the same edge that raises wb_ack_o.
REQ-022 SHALL register wb_dat_o on that same edge, holding the value read before the write; wb_dat_o is 0 when wb_ack_o is low.
REQ-023 SHALL ignore writes to IVR and have no other side effect from them.

Reset
REQ-024 SHALL, while sys_rst_i is high, asynchronously clear s1, s2, the edge flop, ISR, IER, MER, wb_ack_o, wb_dat_o and irq_o to 0.
REQ-025 SHALL abort any transfer in progress at reset with no register update; after release, a still-high wb_stb_i is acknowledged per REQ-019.
REQ-026 SHALL, after reset release, not raise irq_o until software sets both IER and MER[0].
REQ-027 SHALL not set any ISR bit earlier than the 2nd rising edge after reset release.

Configuration
REQ-028 SHALL use the preprocessor macro AEMB_INTC_EDGE_EN to select the source trigger mode.
REQ-029 SHALL, with AEMB_INTC_EDGE_EN defined, add a third flop s3 per source.
REQ-030 SHALL, with AEMB_INTC_EDGE_EN defined, use s2 & !s3 as the set condition, so ISR[i] stays set after the source drops until cleared.
REQ-031 SHALL, with AEMB_INTC_EDGE_EN undefined, omit s3 and use s2 as the set condition (level mode).
REQ-032 SHALL, in level mode, re-set ISR[i] on the next edge after a W1C while the source stays high.

Verification
REQ-033 SHALL cover basic assert: IER=0x01, MER=1, int_src_i[0] rises before edge 0 -> ISR[0]=1 after edge 2, irq_o=1 after edge 3, IVR=0x80000000.
REQ-034 SHALL cover priority: IER=0xFF, MER=1, sources 5 and 2 raised together -> IVR reads 0x80000002; then ISR write 0x04 -> IVR reads 0x80000005.
REQ-035 SHALL cover set/clear collision: edge mode, ISR write 0x08 in the same cycle source 3 sets -> ISR[3] remains 1.
REQ-036 SHALL cover masking: ISR=0x10, IER=0x10, MER=0 -> irq_o=0; write MER=1 -> irq_o=1 one edge after the write ack.
REQ-037 SHALL cover edge vs level: source 1 held high and ISR write 0x02 -> edge build reads ISR=0, level build reads ISR=0x02.
REQ-038 SHALL cover reset mid-access: sys_rst_i pulsed during a cycle with wb_stb_i high and wb_we_i high to IER -> wb_ack_o=0 and IER=0 immediately; after release, ack arrives on the next edge.
